// File: rtl/banco_registros_param.sv
// -----------------------------------------------------------------------------
// banco_registros_param
//
// Purpose:
//   DEPTH x N register file for the datapath (DEPTH = 2**ADDR_W).
//   - One write port, gated off while a bulk clear is running.
//   - Two addressed read ports, each registered (one-cycle latency).
//   - Write-first bypass: a write accepted at an edge is returned by any read
//     port addressing the same entry at that same edge.
//   - Bulk-clear engine: zeroes one entry per clock, DEPTH clocks in total,
//     with busy/done status and a write-error pulse for writes it rejects.
//
// Parameters:
//   N       data width in bits (>= 1)
//   ADDR_W  address width; DEPTH = 2**ADDR_W entries
//
// Ports:
//   clk   in   1       clock, rising edge
//   rst   in   1       asynchronous, active-high reset
//   w     in   1       write enable
//   wa    in   ADDR_W  write address
//   s     in   N       write data
//   ra1   in   ADDR_W  read address, port 1
//   ra2   in   ADDR_W  read address, port 2
//   clr   in   1       bulk-clear request (level, sampled on the clock edge)
//   r1    out  N       read data, port 1 (registered)
//   r2    out  N       read data, port 2 (registered)
//   busy  out  1       high while the bulk clear is in progress
//   done  out  1       one-cycle pulse after the last entry is cleared
//   werr  out  1       one-cycle pulse: write attempted while busy
// -----------------------------------------------------------------------------
module banco_registros_param #(
    parameter int N      = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w,
    input  logic [ADDR_W-1:0] wa,
    input  logic [N-1:0]      s,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              clr,
    output logic [N-1:0]      r1,
    output logic [N-1:0]      r2,
    output logic              busy,
    output logic              done,
    output logic              werr
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Final sweep index; reaching it is the only terminating condition.
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic [N-1:0]      mem_q [DEPTH];
    logic [N-1:0]      mem_d [DEPTH];
    logic [N-1:0]      r1_q,    r1_d;
    logic [N-1:0]      r2_q,    r2_d;
    logic              done_q,  done_d;
    logic              werr_q,  werr_d;

    // Qualified actions for this edge.
    logic wr_en;     // write accepted into the array
    logic sweep_en;  // entry cnt_q is zeroed at this edge

    assign wr_en    = w && (state_q == IDLE);
    assign sweep_en = (state_q == CLEARING);

    // -------------------------------------------------------------------------
    // Read-port value as seen after the coming edge.
    // An accepted write wins over the stored value (write-first); the entry
    // being swept reads as zero. The two cases are mutually exclusive because
    // writes are only accepted in IDLE and the sweep only runs in CLEARING.
    // -------------------------------------------------------------------------
    function automatic logic [N-1:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [N-1:0] val;
        val = mem_q[ra];
        if (wr_en && (ra == wa)) begin
            val = s;
        end
        if (sweep_en && (ra == cnt_q)) begin
            val = '0;
        end
        return val;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic: clear sequencer, status pulses, array update, reads.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        werr_d  = 1'b0;
        mem_d   = mem_q;

        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEARING;
                    cnt_d   = '0;
                end
            end
            CLEARING: begin
                // clr is ignored here; the sweep never restarts mid-way.
                werr_d = w;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A write presented with the clr edge is still performed; the sweep
        // that follows zeroes it like every other entry.
        if (wr_en) begin
            mem_d[wa] = s;
        end
        if (sweep_en) begin
            mem_d[cnt_q] = '0;
        end

        r1_d = read_port(ra1);
        r2_d = read_port(ra2);
    end

    // -------------------------------------------------------------------------
    // Control and output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            done_q  <= 1'b0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            done_q  <= done_d;
            werr_q  <= werr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: this array is deliberately reset: every entry must read zero
        // straight after reset, so it is built from resettable flops rather
        // than a RAM macro that would power up undefined.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. busy is the state flop itself (CLEARING encodes as 1).
    // -------------------------------------------------------------------------
    assign busy = (state_q == CLEARING);
    assign done = done_q;
    assign werr = werr_q;
    assign r1   = r1_q;
    assign r2   = r2_q;

endmodule
